// File: rtl/mem_resp_demux_pkg.sv
// Shared types and defaults for the memory response demux and its tag FIFO.
package mem_resp_demux_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT  = 4;

  // Requester that issued a request; stored per outstanding request.
  typedef logic src_t;

  localparam src_t SRC_FETCH = 1'b0;
  localparam src_t SRC_DATA  = 1'b1;

endpackage

// File: rtl/mem_resp_demux_src_tag_fifo.sv
// Synchronous FIFO of requester tags, one entry per outstanding memory request.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module src_tag_fifo
  import mem_resp_demux_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  src_t                     din,
  input  logic                     pop,
  output src_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  src_t             mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = PTR_W'(wr_ptr - rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and storage update; storage is cleared so no stale tag survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= SRC_FETCH;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_resp_demux.sv
// Routes in-order memory responses back to the fetch (A) or data (B) requester.
// Optional MEM_RESP_ERR_EN: sticky err_orphan flag and orphan responses are dropped.
module mem_resp_demux
  import mem_resp_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_src,
  output logic              req_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ready,
  output logic              a_rsp_valid,
  input  logic              a_rsp_ready,
  output logic              b_rsp_valid,
  input  logic              b_rsp_ready,
  output logic [DATA_W-1:0] rsp_data_out,
`ifdef MEM_RESP_ERR_EN
  output logic              err_orphan,
`endif
  output logic [CNT_W-1:0]  outstanding
);

  localparam int unsigned FIFO_CNT_W = $clog2(DEPTH) + 1;

  logic                  full;
  logic                  empty;
  src_t                  head_tag;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  push;
  logic                  pop;
  logic                  route_ready;

  // Request side: full stalls new requests even when a pop lands in the same cycle.
  assign req_ready     = mem_req_ready & ~full;
  assign mem_req_valid = req_valid & ~full;
  assign push          = req_valid & mem_req_ready & ~full;

  // Response side: zero-latency steering by the oldest outstanding tag.
  assign route_ready  = (head_tag == SRC_DATA) ? b_rsp_ready : a_rsp_ready;
  assign a_rsp_valid  = rsp_valid & ~empty & (head_tag == SRC_FETCH);
  assign b_rsp_valid  = rsp_valid & ~empty & (head_tag == SRC_DATA);
  assign rsp_data_out = rsp_data;

`ifdef MEM_RESP_ERR_EN
  // Orphans are swallowed so memory never deadlocks on an unexpected response.
  assign rsp_ready = empty ? rsp_valid : route_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan <= 1'b0;
    end else if (rsp_valid && empty) begin
      err_orphan <= 1'b1;
    end
  end
`else
  assign rsp_ready = ~empty & route_ready;
`endif

  assign pop         = rsp_valid & rsp_ready & ~empty;
  assign outstanding = CNT_W'(fifo_count);

  src_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (src_t'(req_src)),
    .pop   (pop),
    .dout  (head_tag),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_mem_resp_demux.sv
// Directed self-checking bench for mem_resp_demux (DEPTH = 4, DATA_W = 32).
module tb_mem_resp_demux;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_src;
  logic              req_ready;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ready;
  logic              a_rsp_valid;
  logic              a_rsp_ready;
  logic              b_rsp_valid;
  logic              b_rsp_ready;
  logic [DATA_W-1:0] rsp_data_out;
  logic [CNT_W-1:0]  outstanding;
`ifdef MEM_RESP_ERR_EN
  logic              err_orphan;
`endif

  int checks   = 0;
  int failures = 0;

  mem_resp_demux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_src       (req_src),
    .req_ready     (req_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .a_rsp_valid   (a_rsp_valid),
    .a_rsp_ready   (a_rsp_ready),
    .b_rsp_valid   (b_rsp_valid),
    .b_rsp_ready   (b_rsp_ready),
    .rsp_data_out  (rsp_data_out),
`ifdef MEM_RESP_ERR_EN
    .err_orphan    (err_orphan),
`endif
    .outstanding   (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks occur mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b0110;

    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_src       = 1'b0;
    mem_req_ready = 1'b1;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    a_rsp_ready   = 1'b0;
    b_rsp_ready   = 1'b0;

    // Reset values
    #2;
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_a_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_b_valid", 32'(b_rsp_valid), 32'd0);
    chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("rst_req_ready_hi", 32'(req_ready), 32'd1);
    mem_req_ready = 1'b0;
    settle();
    chk("rst_req_ready_lo", 32'(req_ready), 32'd0);
    mem_req_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Push A, B, A
    req_valid = 1'b1;
    req_src   = 1'b0;
    settle();
    chk("push_req_ready", 32'(req_ready), 32'd1);
    chk("push_mem_req_valid", 32'(mem_req_valid), 32'd1);
    tick();
    chk("push1_outstanding", 32'(outstanding), 32'd1);
    req_src = 1'b1;
    tick();
    req_src = 1'b0;
    tick();
    req_valid = 1'b0;
    settle();
    chk("push3_outstanding", 32'(outstanding), 32'd3);

    // Return 0x11, 0x22, 0x33
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    rsp_valid   = 1'b1;
    rsp_data    = 32'h11;
    settle();
    chk("rsp11_a_valid", 32'(a_rsp_valid), 32'd1);
    chk("rsp11_b_valid", 32'(b_rsp_valid), 32'd0);
    chk("rsp11_rsp_ready", 32'(rsp_ready), 32'd1);
    chk("rsp11_data", rsp_data_out, 32'h11);
    tick();
    rsp_data = 32'h22;
    settle();
    chk("rsp22_a_valid", 32'(a_rsp_valid), 32'd0);
    chk("rsp22_b_valid", 32'(b_rsp_valid), 32'd1);
    chk("rsp22_data", rsp_data_out, 32'h22);
    tick();
    rsp_data = 32'h33;
    settle();
    chk("rsp33_a_valid", 32'(a_rsp_valid), 32'd1);
    chk("rsp33_b_valid", 32'(b_rsp_valid), 32'd0);
    tick();
    rsp_valid = 1'b0;
    settle();
    chk("drain_outstanding", 32'(outstanding), 32'd0);

    // Fill to DEPTH with A, B, B, A; fifth request must stall
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_src = pat[i];
      tick();
    end
    req_src = 1'b0;
    settle();
    chk("full_outstanding", 32'(outstanding), 32'd4);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    chk("full_mem_req_valid", 32'(mem_req_valid), 32'd0);
    // Pop while full: push stays blocked this cycle
    rsp_valid = 1'b1;
    rsp_data  = 32'hA0;
    settle();
    chk("full_pop_a_valid", 32'(a_rsp_valid), 32'd1);
    chk("full_pop_req_ready", 32'(req_ready), 32'd0);
    tick();
    rsp_valid = 1'b0;
    settle();
    chk("after_pop_outstanding", 32'(outstanding), 32'd3);
    chk("after_pop_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    settle();
    chk("refill_outstanding", 32'(outstanding), 32'd4);

    // Head is B with B not ready: stall three cycles
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b0;
    rsp_valid   = 1'b1;
    rsp_data    = 32'hB1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_rsp_ready", 32'(rsp_ready), 32'd0);
      chk("stall_b_valid", 32'(b_rsp_valid), 32'd1);
      chk("stall_a_valid", 32'(a_rsp_valid), 32'd0);
      tick();
    end
    chk("stall_outstanding", 32'(outstanding), 32'd4);
    b_rsp_ready = 1'b1;
    settle();
    chk("unstall_rsp_ready", 32'(rsp_ready), 32'd1);
    tick();
    rsp_valid = 1'b0;
    settle();
    chk("unstall_outstanding", 32'(outstanding), 32'd3);

    // Pop the second B, leaving A, A at count 2
    rsp_valid = 1'b1;
    rsp_data  = 32'hB2;
    settle();
    chk("b2_b_valid", 32'(b_rsp_valid), 32'd1);
    tick();
    rsp_valid = 1'b0;
    settle();
    chk("cnt2_outstanding", 32'(outstanding), 32'd2);

    // Simultaneous push (B) and pop at count 2
    req_valid = 1'b1;
    req_src   = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h44;
    settle();
    chk("pp_a_valid", 32'(a_rsp_valid), 32'd1);
    chk("pp_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    settle();
    chk("pp_outstanding", 32'(outstanding), 32'd2);
    rsp_valid = 1'b1;
    rsp_data  = 32'h55;
    settle();
    chk("pp55_a_valid", 32'(a_rsp_valid), 32'd1);
    chk("pp55_b_valid", 32'(b_rsp_valid), 32'd0);
    tick();
    rsp_data = 32'h66;
    settle();
    chk("pp66_b_valid", 32'(b_rsp_valid), 32'd1);
    chk("pp66_data", rsp_data_out, 32'h66);
    tick();
    rsp_valid = 1'b0;
    settle();
    chk("pp_drain_outstanding", 32'(outstanding), 32'd0);

    // Orphan response while empty
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD;
    settle();
    chk("orphan_a_valid", 32'(a_rsp_valid), 32'd0);
    chk("orphan_b_valid", 32'(b_rsp_valid), 32'd0);
`ifdef MEM_RESP_ERR_EN
    chk("orphan_rsp_ready", 32'(rsp_ready), 32'd1);
    chk("orphan_err_pre", 32'(err_orphan), 32'd0);
`else
    chk("orphan_rsp_ready", 32'(rsp_ready), 32'd0);
`endif
    tick();
    rsp_valid = 1'b0;
    settle();
    chk("orphan_outstanding", 32'(outstanding), 32'd0);
`ifdef MEM_RESP_ERR_EN
    chk("orphan_err_sticky", 32'(err_orphan), 32'd1);
`endif

    // Reset mid-operation discards outstanding tags
    req_valid = 1'b1;
    req_src   = 1'b1;
    tick();
    tick();
    req_valid = 1'b0;
    settle();
    chk("pre_rst_outstanding", 32'(outstanding), 32'd2);
    rst_n = 1'b0;
    settle();
    chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
    rsp_valid = 1'b1;
    settle();
    chk("mid_rst_b_valid", 32'(b_rsp_valid), 32'd0);
`ifdef MEM_RESP_ERR_EN
    chk("mid_rst_err", 32'(err_orphan), 32'd0);
`endif
    rsp_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_resp_demux.md
Name: mem_resp_demux

Overview:
- Sits between the fetch/data request arbiter and the single shared memory port of the RISC-V core.
- The arbiter is the select/merge direction; this block is the return direction. It records which requester issued each accepted request, then routes the in-order memory responses back to that requester: port A for instruction fetch, port B for load/store.
- Outstanding requests are tracked in a small tag FIFO. New requests are back-pressured when the FIFO is full.

Parameters:
- DATA_W, 32, width of the response data bus.
- DEPTH, 4, maximum outstanding requests. Must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the outstanding-count output.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  arbiter has a request.
- req_src  in  1  requester of that request: 0 = fetch (A), 1 = data (B).
- req_ready  out  1  request accepted this cycle; equals mem_req_ready & ~full.
- mem_req_valid  out  1  forwarded to memory; equals req_valid & ~full.
- mem_req_ready  in  1  memory can accept a request.
- rsp_valid  in  1  memory response valid.
- rsp_data  in  DATA_W  memory response data.
- rsp_ready  out  1  response consumed.
- a_rsp_valid  out  1  response valid for fetch.
- a_rsp_ready  in  1  fetch can take the response.
- b_rsp_valid  out  1  response valid for data.
- b_rsp_ready  in  1  data can take the response.
- rsp_data_out  out  DATA_W  rsp_data broadcast to both requesters.
- outstanding  out  CNT_W  number of accepted requests not yet answered.

Behaviour:
- Reset (async assert, synchronous to clk on release):
  - FIFO pointers and count cleared; outstanding = 0.
  - a_rsp_valid = b_rsp_valid = rsp_ready = 0.
  - req_ready follows mem_req_ready.
- Push: on req_valid & mem_req_ready & ~full, req_src is written at the tail and the tail pointer advances modulo DEPTH.
- Full blocks the push even if a pop occurs in the same cycle, so there is no full-cycle bypass.
- Head tag: tag = FIFO[head], registered. It is valid only when ~empty.
- Routing is combinational, with zero added latency on the response path:
  - a_rsp_valid = rsp_valid & ~empty & (tag == 0)
  - b_rsp_valid = rsp_valid & ~empty & (tag == 1)
  - rsp_ready = ~empty & (tag ? b_rsp_ready : a_rsp_ready)
- Pop: on rsp_valid & rsp_ready, the head advances modulo DEPTH.
- Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
- Empty with rsp_valid high (orphan response): not routed, rsp_ready = 0, no state change.
- A request pushed in cycle N can be answered no earlier than cycle N+1. Memory guarantees at least one cycle of latency.
- Responses return in request order; no reordering is supported.
- Pointer wrap: pointers are log2(DEPTH)+1 bits wide. Full when the MSBs differ and the LSBs are equal; empty when the pointers are equal.
- Reset mid-operation discards all outstanding tags. Memory is reset by the same rst_n.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- When defined:
  - Adds output err_orphan (1 bit), a sticky flag set when rsp_valid is high while the FIFO is empty.
  - err_orphan is cleared only by rst_n.
  - The orphan response is still dropped with rsp_ready = 1, so the memory cannot deadlock.
- When undefined: no err_orphan port, and orphan responses stall as described in Behaviour (rsp_ready = 0).

Decomposition:
- Shared package holds:
  - SRC_FETCH = 1'b0 and SRC_DATA = 1'b1.
  - A typedef for the 1-bit source tag.
  - Default DEPTH.
- One sub-module, src_tag_fifo: a parameterised synchronous FIFO with full, empty and count outputs.
- Routing logic stays in the top level.

Test Plan:
- Reset → outstanding = 0, a/b_rsp_valid = 0, rsp_ready = 0; req_ready equals mem_req_ready.
- Push A, B, A with mem_req_ready = 1, then return responses 0x11, 0x22, 0x33 → A receives 0x11, B receives 0x22, A receives 0x33, outstanding back to 0.
- Four pushes with DEPTH = 4 → req_ready = 0 and mem_req_valid = 0 on the fifth request. Pop one response → req_ready returns the next cycle.
- Head tag B with b_rsp_ready = 0 for 3 cycles → rsp_ready = 0 and no pop. Raise b_rsp_ready → a single pop.
- Same-cycle push and pop at count 2 → count stays 2, and the next response is routed per the older tag.
- rsp_valid while empty → no valid output and rsp_ready = 0. With MEM_RESP_ERR_EN defined: err_orphan = 1 and rsp_ready = 1.
